// File: rtl/sar_number_finder.sv
// Successive-approximation search engine: drives trial guesses to an external
// magnitude comparator and narrows in on the target one bit per verdict.
module sar_number_finder #(
   parameter int WIDTH  = 5,
   parameter int STEP_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [WIDTH-1:0]  guess,
   output logic              guess_valid,
   input  logic              cmp_valid,
   input  logic              cmp_gt,
   input  logic              cmp_eq,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic [STEP_W-1:0] steps,
   output logic [1:0]        state_dbg
);

   // Handshake: guess is held stable while guess_valid=1; a verdict is consumed
   // on any cycle with guess_valid=1 and cmp_valid=1, including the first one.

   localparam int IDX_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  acc, acc_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [STEP_W-1:0] step_cnt, step_n;
   logic [WIDTH-1:0]  result_q, result_n;
   logic [STEP_W-1:0] steps_q, steps_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         idx      <= '0;
         step_cnt <= '0;
         result_q <= '0;
         steps_q  <= '0;
      end else begin
         state    <= state_n;
         acc      <= acc_n;
         idx      <= idx_n;
         step_cnt <= step_n;
         result_q <= result_n;
         steps_q  <= steps_n;
      end
   end

   always_comb begin
      state_n  = state;
      acc_n    = acc;
      idx_n    = idx;
      step_n   = step_cnt;
      result_n = result_q;
      steps_n  = steps_q;
      case (state)
         IDLE: begin
            if (start) begin
               acc_n            = '0;
               acc_n[WIDTH-1]   = 1'b1;
               idx_n            = IDX_W'(WIDTH - 1);
               step_n           = '0;
               state_n          = ISSUE;
            end
         end
         ISSUE: begin
            if (cmp_valid) begin
               step_n = step_cnt + STEP_W'(1);
               if (cmp_eq) begin
                  result_n = acc;
                  steps_n  = step_n;
                  state_n  = FINISH;
               end else begin
                  if (cmp_gt) acc_n[idx] = 1'b0;
                  if (idx == '0) begin
                     result_n = acc_n;
                     steps_n  = step_n;
                     state_n  = FINISH;
                  end else begin
                     // Trial-set the next lower bit for the following guess.
                     idx_n        = idx - IDX_W'(1);
                     acc_n[idx_n] = 1'b1;
                  end
               end
            end
         end
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign guess       = (state == ISSUE) ? acc : '0;
   assign guess_valid = (state == ISSUE);
   assign busy        = (state == ISSUE);
   assign done        = (state == FINISH);
   assign result      = result_q;
   assign steps       = steps_q;
   assign state_dbg   = state;

endmodule

// File: tb/tb_sar_number_finder.sv
// Directed bench for sar_number_finder: a comparator model answers guesses,
// a done-monitor pops expected {result, steps} from a scoreboard queue.
module tb_sar_number_finder;

   localparam int W  = 5;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  guess;
   logic          guess_valid;
   logic          cmp_valid = 1'b0;
   logic          cmp_gt    = 1'b0;
   logic          cmp_eq    = 1'b0;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic [SW-1:0] steps;
   logic [1:0]    state_dbg;

   int compared   = 0;
   int mismatched = 0;

   logic [W-1:0]    gexp_q[$];
   logic [W+SW-1:0] exp_q[$];

   logic [W-1:0]  target     = '0;
   int            resp_delay = 0;
   bit            gt_with_eq = 1'b0;
   bit            idle_noise = 1'b0;
   int            wait_cnt   = 0;
   logic [W-1:0]  held_guess = '0;
   logic [W-1:0]  last_res   = '0;
   logic [SW-1:0] last_steps = '0;

   sar_number_finder #(.WIDTH(W), .STEP_W(SW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .guess(guess), .guess_valid(guess_valid),
      .cmp_valid(cmp_valid), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq),
      .busy(busy), .done(done), .result(result), .steps(steps),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Comparator model: answers after resp_delay waiting cycles, checks each guess.
   always @(negedge clk) begin
      if (guess_valid) begin
         if (wait_cnt >= resp_delay) begin
            cmp_valid = 1'b1;
            cmp_eq    = (guess == target);
            cmp_gt    = (guess > target) || (gt_with_eq && guess == target);
            if (gexp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL guess_unexpected: got guess %0d expected none", guess);
            end else begin
               check("guess", guess, gexp_q.pop_front());
            end
            wait_cnt = 0;
         end else begin
            if (wait_cnt == 0) held_guess = guess;
            else check("guess_stable", guess, held_guess);
            cmp_valid = 1'b0;
            cmp_eq    = 1'b0;
            cmp_gt    = 1'b0;
            wait_cnt++;
         end
      end else begin
         wait_cnt  = 0;
         cmp_valid = idle_noise && !cmp_valid;
         cmp_eq    = cmp_valid;
         cmp_gt    = 1'b0;
      end
   end

   // Done monitor: every done pulse must match the oldest pending search.
   always @(negedge clk) begin
      if (done) begin
         check("done_busy", busy, 0);
         check("done_guess_valid", guess_valid, 0);
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL done_unexpected: got done=1 expected no pending search");
         end else begin
            logic [W+SW-1:0] e;
            e = exp_q.pop_front();
            check("result", result, e[W+SW-1:SW]);
            check("steps", steps, e[SW-1:0]);
         end
      end
   end

   task automatic run_search(input logic [W-1:0] tgt, input int dly,
                             input logic [5*W-1:0] gv, input int n,
                             input logic [W-1:0] exp_res, input logic [SW-1:0] exp_steps,
                             input int lat, input bit noise);
      int cnt;
      bit got;
      target     = tgt;
      resp_delay = dly;
      for (int i = 0; i < n; i++) gexp_q.push_back(gv[i*W +: W]);
      exp_q.push_back({exp_res, exp_steps});
      @(posedge clk) #1 start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      cnt = 1;
      got = 1'b0;
      while (!got && cnt < 200) begin
         @(negedge clk);
         cnt++;
         if (cnt == 2) begin
            check("guess_valid_rise", guess_valid, 1);
            check("result_held", result, last_res);
            check("steps_held", steps, last_steps);
         end
         if (done) got = 1'b1;
         else if (noise && busy && (cnt % 4 == 0)) start = 1'b1;
         else start = 1'b0;
      end
      start = 1'b0;
      if (!got) begin
         compared++;
         mismatched++;
         $display("FAIL done_timeout: got no done in %0d cycles expected done", cnt);
      end else if (lat > 0) begin
         check("latency", cnt, lat);
      end
      @(negedge clk);
      check("done_single", done, 0);
      last_res   = exp_res;
      last_steps = exp_steps;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_guess"}, guess, 0);
      check({tag, "_guess_valid"}, guess_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_steps"}, steps, 0);
      check({tag, "_state"}, state_dbg, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      bit found;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk) #1 rst = 1'b0;

      run_search(5'd21, 0, {5'd21, 5'd22, 5'd20, 5'd24, 5'd16}, 5, 5'd21, 3'd5, 7, 1'b0);
      run_search(5'd16, 0, {20'd0, 5'd16}, 1, 5'd16, 3'd1, 3, 1'b0);
      run_search(5'd0, 0, {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}, 5, 5'd0, 3'd5, 7, 1'b0);
      run_search(5'd31, 0, {5'd31, 5'd30, 5'd28, 5'd24, 5'd16}, 5, 5'd31, 3'd5, 7, 1'b0);

      // Verdict pulses while idle must not disturb anything.
      idle_noise = 1'b1;
      repeat (6) @(negedge clk);
      idle_noise = 1'b0;
      @(negedge clk);
      check("idle_state", state_dbg, 0);
      check("idle_busy", busy, 0);
      check("idle_result", result, last_res);
      check("idle_steps", steps, last_steps);

      run_search(5'd9, 3, {5'd9, 5'd10, 5'd12, 5'd8, 5'd16}, 5, 5'd9, 3'd5, 0, 1'b1);

      // Reset during the third guess of a search for 21.
      target     = 5'd21;
      resp_delay = 0;
      gexp_q.push_back(5'd16);
      gexp_q.push_back(5'd24);
      gexp_q.push_back(5'd20);
      @(posedge clk) #1 start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      cnt   = 0;
      found = 1'b0;
      while (!found && cnt < 50) begin
         @(negedge clk);
         cnt++;
         if (guess_valid && guess == 5'd20) found = 1'b1;
      end
      if (!found) begin
         compared++;
         mismatched++;
         $display("FAIL third_guess_timeout: got guess %0d expected 20", guess);
      end
      rst = 1'b1;
      @(posedge clk) #1 rst = 1'b0;
      @(negedge clk);
      check_all_zero("midreset");
      last_res   = '0;
      last_steps = '0;

      run_search(5'd5, 0, {5'd5, 5'd6, 5'd4, 5'd8, 5'd16}, 5, 5'd5, 3'd5, 7, 1'b0);

      gt_with_eq = 1'b1;
      run_search(5'd16, 0, {20'd0, 5'd16}, 1, 5'd16, 3'd1, 3, 1'b0);
      gt_with_eq = 1'b0;

      repeat (2) @(negedge clk);
      check("pending_results", exp_q.size(), 0);
      check("pending_guesses", gexp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sar_number_finder.md
Name: sar_number_finder

Overview:
- Successive-approximation search engine. Finds an unknown WIDTH-bit target by issuing trial guesses to an external magnitude comparator and consuming its verdicts.
- Acts as the initiator/driver side of the team's comparator blocks: the comparator answers "is the guess greater than, or equal to, the target"; this block decides what to ask next.
- Terminates early on equality; otherwise finishes after WIDTH comparisons. Reports the result and the number of comparisons used.

Parameters:
- WIDTH, 5, operand/target width in bits (>= 2).
- STEP_W, 3, width of the comparison counter; must satisfy 2^STEP_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new search; sampled only in IDLE.
- guess  output  WIDTH  current trial value presented to the comparator.
- guess_valid  output  1  guess is valid and awaiting a verdict.
- cmp_valid  input  1  comparator verdict valid this cycle (single-cycle pulse).
- cmp_gt  input  1  verdict: guess > target.
- cmp_eq  input  1  verdict: guess == target.
- busy  output  1  search in progress.
- done  output  1  one-cycle pulse when the search completes.
- result  output  WIDTH  found target; held from the done pulse until the next accepted start.
- steps  output  STEP_W  number of verdicts consumed by the last search; held like result.

Behaviour:
- States: IDLE, ISSUE, FINISH.
- Reset: on rst=1 at a clock edge, go to IDLE. Reset overrides all other inputs, including mid-search. After reset, every output is 0: guess, guess_valid, busy, done, result, steps.
- Internal state: acc (WIDTH bits), bit index idx, step counter.
- IDLE:
  - busy=0, guess_valid=0.
  - On start=1: acc = 1 << (WIDTH-1), idx = WIDTH-1, step counter = 0; go to ISSUE.
  - guess_valid rises the cycle after start is sampled.
- ISSUE:
  - busy=1, guess_valid=1, guess=acc.
  - guess is stable for as long as guess_valid is high.
  - Waits indefinitely for cmp_valid. The verdict may arrive in the same cycle guess_valid first rises, or any later cycle.
  - On cmp_valid=1, the step counter increments and:
    - cmp_eq=1 (takes priority over cmp_gt): final = acc; go to FINISH.
    - cmp_eq=0, cmp_gt=1: clear bit idx of acc.
    - cmp_eq=0, cmp_gt=0: keep bit idx.
    - If idx == 0 (and not eq): final = updated acc; go to FINISH.
    - Otherwise: idx decrements, bit idx-1 of acc is set, stay in ISSUE. The new guess appears the next cycle; guess_valid stays high throughout.
- FINISH (one cycle):
  - done=1, busy=0, guess_valid=0.
  - result = final; steps = step counter (includes the terminating verdict).
  - Go to IDLE.
- Other rules:
  - start is ignored in ISSUE and FINISH (no restart, no queuing).
  - cmp_valid/cmp_gt/cmp_eq are ignored outside ISSUE.
  - steps ranges from 1 to WIDTH. Without early equality, exactly WIDTH verdicts are consumed.
  - result and steps are not cleared by start. They update only at FINISH or on reset.
  - Latency with a zero-wait comparator (verdict in the same cycle as guess_valid): start to done is k+2 cycles, where k is the number of comparisons.

Test Plan:
- Target 21, zero-wait responder:
  - guesses 16(lt), 24(gt), 20(lt), 22(gt), 21(eq) -> result=21, steps=5, done pulses once, busy low the same cycle.
- Target 16 -> first guess 16 returns eq -> result=16, steps=1, only one guess_valid cycle.
- Target 0:
  - guesses 16, 8, 4, 2, 1, all gt, no eq -> result=0, steps=5.
  - Target 31: guesses 16, 24, 28, 30, 31 -> result=31, steps=5.
- Responder delays cmp_valid 3 cycles per guess, target 9:
  - guess and guess_valid stay stable while waiting; start pulses mid-search are ignored; cmp_valid pulses while in IDLE have no effect -> result=9, steps=5.
- Reset mid-search:
  - rst asserted during the 3rd guess -> next cycle all outputs 0, state IDLE.
  - Subsequent start with target 5 -> result=5, steps=5.
- cmp_eq=1 and cmp_gt=1 together on guess 16 -> treated as eq: result=16, steps=1.
